// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two pipeline requesters, the arbiter and the shared
// unified memory. Signal suffixes are relative to the arbiter: _i is driven
// into the arbiter, _o is driven by it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   // Instruction fetch requester (read-only)
   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic [DATA_W-1:0] if_data_o;
   logic              if_ready_o;

   // Data access requester (load/store)
   logic              d_req_i;
   logic              d_write_i;
   logic [ADDR_W-1:0] d_addr_i;
   logic [DATA_W-1:0] d_wdata_i;
   logic [DATA_W-1:0] d_rdata_o;
   logic              d_ready_o;

   // Pipeline freeze controls
   logic              stall_if_o;
   logic              stall_mem_o;

   // Single-port memory side
   logic              mem_valid_o;
   logic              mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;
   logic              mem_ack_i;

   // Sticky hang indicator
   logic              timeout_err_o;

   // Arbiter side
   modport slave (
      input  if_req_i, if_addr_i,
      output if_data_o, if_ready_o,
      input  d_req_i, d_write_i, d_addr_i, d_wdata_i,
      output d_rdata_o, d_ready_o,
      output stall_if_o, stall_mem_o,
      output mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i,
      output timeout_err_o
   );

   // Environment side: pipeline requesters plus the memory model
   modport master (
      output if_req_i, if_addr_i,
      input  if_data_o, if_ready_o,
      output d_req_i, d_write_i, d_addr_i, d_wdata_i,
      input  d_rdata_o, d_ready_o,
      input  stall_if_o, stall_mem_o,
      input  mem_valid_o, mem_write_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i,
      input  timeout_err_o
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// instruction fetch port and the data access port. Data has priority, a
// starvation counter forces a fetch grant after STARVE_MAX consecutive data
// grants while fetch waits, and a watchdog aborts transactions whose ack never
// arrives. At most one memory transaction is outstanding.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,    // 1..15
   parameter int TIMEOUT    = 64    // 2..255
) (
   input logic              clk,
   input logic              rst_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_D = 2'd1,
      ST_BUSY_I = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);
   localparam logic [7:0] WAIT_LAST    = 8'(TIMEOUT - 1);

   state_t            state_q,       state_d;
   logic              mem_valid_q,   mem_valid_d;
   logic              mem_write_q,   mem_write_d;
   logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
   logic [DATA_W-1:0] if_data_q,     if_data_d;
   logic [DATA_W-1:0] d_rdata_q,     d_rdata_d;
   logic              if_ready_q,    if_ready_d;
   logic              d_ready_q,     d_ready_d;
   logic              timeout_err_q, timeout_err_d;
   logic [3:0]        starve_cnt_q,  starve_cnt_d;
   logic [7:0]        wait_cnt_q,    wait_cnt_d;

   // Fetch wins only when data is idle or fetch has been passed over too often
   logic grant_if;
   logic grant_d;
   logic wait_expired;

   assign grant_if     = bus.if_req_i && (!bus.d_req_i || (starve_cnt_q == STARVE_LIMIT));
   assign grant_d      = !grant_if && bus.d_req_i;
   assign wait_expired = (wait_cnt_q == WAIT_LAST);

   // Next-state and datapath decisions for the arbitration FSM
   always_comb begin
      state_d       = state_q;
      mem_valid_d   = mem_valid_q;
      mem_write_d   = mem_write_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      if_data_d     = if_data_q;
      d_rdata_d     = d_rdata_q;
      if_ready_d    = 1'b0;           // ready is a single-cycle pulse
      d_ready_d     = 1'b0;
      timeout_err_d = timeout_err_q;
      starve_cnt_d  = starve_cnt_q;
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         ST_IDLE: begin
            // Any stray memAck here is simply not looked at
            if (grant_if) begin
               state_d      = ST_BUSY_I;
               mem_valid_d  = 1'b1;
               mem_write_d  = 1'b0;
               mem_addr_d   = bus.if_addr_i;
               wait_cnt_d   = '0;
               starve_cnt_d = '0;
            end else if (grant_d) begin
               state_d     = ST_BUSY_D;
               mem_valid_d = 1'b1;
               mem_write_d = bus.d_write_i;
               mem_addr_d  = bus.d_addr_i;
               mem_wdata_d = bus.d_wdata_i;
               wait_cnt_d  = '0;
               // Count only grants that made a waiting fetch wait longer
               if (!bus.if_req_i) begin
                  starve_cnt_d = '0;
               end else if (starve_cnt_q != STARVE_LIMIT) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end

         ST_BUSY_D, ST_BUSY_I: begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            // An ack on the last allowed cycle still counts as success
            if (bus.mem_ack_i) begin
               state_d     = ST_DONE;
               mem_valid_d = 1'b0;
               if (state_q == ST_BUSY_I) begin
                  if_data_d  = bus.mem_rdata_i;
                  if_ready_d = 1'b1;
               end else begin
                  if (!mem_write_q) begin
                     d_rdata_d = bus.mem_rdata_i;
                  end
                  d_ready_d = 1'b1;
               end
            end else if (wait_expired) begin
               // Abort: release the requester with a zero result and flag it
               state_d       = ST_DONE;
               mem_valid_d   = 1'b0;
               timeout_err_d = 1'b1;
               if (state_q == ST_BUSY_I) begin
                  if_data_d  = '0;
                  if_ready_d = 1'b1;
               end else begin
                  d_rdata_d = '0;
                  d_ready_d = 1'b1;
               end
            end
         end

         ST_DONE: begin
            // Requester sees ready this cycle; give it a cycle to move on
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         mem_valid_q   <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         if_data_q     <= '0;
         d_rdata_q     <= '0;
         if_ready_q    <= 1'b0;
         d_ready_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         starve_cnt_q  <= '0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         mem_valid_q   <= mem_valid_d;
         mem_write_q   <= mem_write_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         if_data_q     <= if_data_d;
         d_rdata_q     <= d_rdata_d;
         if_ready_q    <= if_ready_d;
         d_ready_q     <= d_ready_d;
         timeout_err_q <= timeout_err_d;
         starve_cnt_q  <= starve_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   // Registered outputs
   assign bus.if_data_o     = if_data_q;
   assign bus.if_ready_o    = if_ready_q;
   assign bus.d_rdata_o     = d_rdata_q;
   assign bus.d_ready_o     = d_ready_q;
   assign bus.mem_valid_o   = mem_valid_q;
   assign bus.mem_write_o   = mem_write_q;
   assign bus.mem_addr_o    = mem_addr_q;
   assign bus.mem_wdata_o   = mem_wdata_q;
   assign bus.timeout_err_o = timeout_err_q;

   // Stalls follow the raw request so the pipeline freezes in the same cycle
   assign bus.stall_if_o  = bus.if_req_i & ~if_ready_q;
   assign bus.stall_mem_o = bus.d_req_i  & ~d_ready_q;

endmodule
